bcd_serial_alu: RTL and testbench

Parametrised bit-serial BCD arithmetic unit: hunts a serial input stream for a sync header, captures an opcode and two DIGITS-wide packed-BCD operands, and computes add, subtract or compare one digit per cycle. The result goes out serially behind a response header. Successor to the fixed 4-digit add/subtract serial unit, adding:
- a digit-count parameter
- a compare mode
- BCD validity checking with an error header
- framed output valid and busy status

It sits between the serial link front end and the serial response path.

---
 rtl/bcd_serial_alu.sv | 164 ++++++++++++++++
 tb/tb_bcd_serial_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_alu.sv
// Bit-serial BCD add/subtract/compare unit: hunts for a sync header, receives op + two
// packed-BCD operands, computes one digit per cycle and returns a framed serial result.
//
// state | meaning
// HUNT  | sliding 8-bit window looks for SYNC_HDR
// RECV  | shifting in op, A and B
// CALC  | one BCD digit per cycle, LSD first
// SEND  | shifting out header and result, MSB first
module bcd_serial_alu #(
    parameter int unsigned DIGITS   = 4,
    parameter logic [7:0]  SYNC_HDR = 8'h5A,
    parameter logic [7:0]  OK_HDR   = 8'h96,
    parameter logic [7:0]  ERR_HDR  = 8'h69
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic dout_valid,
    output logic busy
);

    localparam int unsigned AW   = 4 * DIGITS;
    localparam int unsigned LOUT = 12 + 4 * DIGITS;
    localparam logic [6:0] RECV_LOAD = 7'(2 + 8 * DIGITS - 1);
    localparam logic [6:0] CALC_LOAD = 7'(DIGITS - 1);
    localparam logic [6:0] SEND_LOAD = 7'(LOUT - 1);

    typedef enum logic [1:0] {HUNT, RECV, CALC, SEND} state_t;

    state_t          state_q, state_d;
    logic [7:0]      window_q;
    logic [6:0]      cnt_q;
    logic [1:0]      op_q;
    logic [AW-1:0]   a_q, b_q, f_q;
    logic            cy_q, err_q, nz_q;
    logic [LOUT-1:0] tx_q;
    logic            valid_q, busy_q;

    logic [7:0]      window_shift;
    logic [3:0]      a_d, b_d, f_dig;
    logic [4:0]      sum, diff;
    logic            cy_nx, err_nx, nz_nx;
    logic [AW-1:0]   f_nx;
    logic [1:0]      cmp_code;
    logic [LOUT-1:0] result;

    assign dout       = tx_q[LOUT-1];
    assign dout_valid = valid_q;
    assign busy       = busy_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        window_shift = {window_q[6:0], din};
        a_d          = a_q[3:0];
        b_d          = b_q[3:0];
        sum          = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, cy_q};
        diff         = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, cy_q};
        f_dig        = sum[3:0];
        cy_nx        = 1'b0;
        // Adjustments wrap modulo 16; only the low nibble is ever kept.
        if (op_q == 2'b00) begin
            if (sum > 5'd9) begin
                f_dig = sum[3:0] - 4'd10;
                cy_nx = 1'b1;
            end
        end else begin
            f_dig = diff[3:0];
            if (diff[4]) begin
                f_dig = diff[3:0] + 4'd10;
                cy_nx = 1'b1;
            end
        end
        err_nx   = err_q | (a_d > 4'd9) | (b_d > 4'd9) | (op_q == 2'b11);
        nz_nx    = nz_q | (f_dig != 4'd0);
        f_nx     = AW'({f_dig, f_q} >> 4);
        cmp_code = cy_nx ? 2'd2 : (nz_nx ? 2'd1 : 2'd0);
        if (err_nx)
            result = {ERR_HDR, {(AW + 4){1'b0}}};
        else if (op_q == 2'b10)
            result = {OK_HDR, {(AW + 2){1'b0}}, cmp_code};
        else
            result = {OK_HDR, 3'b000, cy_nx, f_nx};

        case (state_q)
            HUNT: if (window_shift == SYNC_HDR) state_d = RECV;
            RECV: if (cnt_q == 7'd0) state_d = CALC;
            CALC: if (cnt_q == 7'd0) state_d = SEND;
            SEND: if (cnt_q == 7'd0) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            cy_q     <= 1'b0;
            err_q    <= 1'b0;
            nz_q     <= 1'b0;
            tx_q     <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    window_q <= window_shift;
                    if (window_shift == SYNC_HDR) cnt_q <= RECV_LOAD;
                end
                RECV: begin
                    // op, A and B form one shift chain; garbage from earlier frames falls off the top.
                    {op_q, a_q, b_q} <= {op_q[0], a_q, b_q, din};
                    if (cnt_q == 7'd0) begin
                        cnt_q <= CALC_LOAD;
                        cy_q  <= 1'b0;
                        err_q <= 1'b0;
                        nz_q  <= 1'b0;
                        f_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                CALC: begin
                    busy_q <= 1'b1;
                    a_q    <= a_q >> 4;
                    b_q    <= b_q >> 4;
                    f_q    <= f_nx;
                    cy_q   <= cy_nx;
                    err_q  <= err_nx;
                    nz_q   <= nz_nx;
                    if (cnt_q == 7'd0) begin
                        tx_q    <= result;
                        valid_q <= 1'b1;
                        cnt_q   <= SEND_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                SEND: begin
                    if (cnt_q == 7'd0) begin
                        tx_q     <= '0;
                        valid_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        window_q <= '0;
                    end else begin
                        tx_q  <= tx_q << 1;
                        cnt_q <= cnt_q - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed bench for bcd_serial_alu: 4-digit instance for the main cases,
// 1- and 8-digit instances for the width extremes.
module tb_bcd_serial_alu;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic din4 = 1'b0, din1 = 1'b0, din8 = 1'b0;
    logic dout4, dv4, busy4, dout1, dv1, busy1, dout8, dv8, busy8;
    logic dout_o, valid_o, busy_o;
    int   sel = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   seen;
    logic [7:0] hdr = 8'h5A;

    always #5 clock = ~clock;

    bcd_serial_alu #(.DIGITS(4)) dut4 (.clock(clock), .reset(reset), .din(din4),
        .dout(dout4), .dout_valid(dv4), .busy(busy4));
    bcd_serial_alu #(.DIGITS(1)) dut1 (.clock(clock), .reset(reset), .din(din1),
        .dout(dout1), .dout_valid(dv1), .busy(busy1));
    bcd_serial_alu #(.DIGITS(8)) dut8 (.clock(clock), .reset(reset), .din(din8),
        .dout(dout8), .dout_valid(dv8), .busy(busy8));

    always_comb begin
        case (sel)
            0:       {dout_o, valid_o, busy_o} = {dout4, dv4, busy4};
            1:       {dout_o, valid_o, busy_o} = {dout1, dv1, busy1};
            default: {dout_o, valid_o, busy_o} = {dout8, dv8, busy8};
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input logic b);
        din4 = (sel == 0) ? b : 1'b0;
        din1 = (sel == 1) ? b : 1'b0;
        din8 = (sel == 2) ? b : 1'b0;
    endtask

    function automatic int digits_of(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 1 : 8);
    endfunction

    // First bit is driven immediately; caller must be sitting at a falling edge.
    // Returns on the falling edge just after the last B bit was sampled.
    task automatic drive_frame(input logic [7:0] prefix, input int plen, input logic [1:0] op,
                               input logic [63:0] a, input logic [63:0] b);
        int d = digits_of(sel);
        int n;
        logic [127:0] bits;
        logic [127:0] mask;
        mask = (128'd1 << (4 * d)) - 128'd1;
        bits = 128'(prefix) & ((128'd1 << plen) - 128'd1);
        bits = (bits << 8) | 128'(hdr);
        bits = (bits << 2) | 128'(op);
        bits = (bits << (4 * d)) | (128'(a) & mask);
        bits = (bits << (4 * d)) | (128'(b) & mask);
        n = plen + 10 + 8 * d;
        for (int i = n - 1; i >= 0; i--) begin
            set_din(bits[i]);
            if (i > 0) @(negedge clock);
        end
        @(negedge clock);
        set_din(1'b0);
    endtask

    task automatic capture(input int lout, input logic [127:0] exp, input string tag);
        int d = digits_of(sel);
        int lat = 0;
        int n = 0;
        logic [127:0] obs = '0;
        chk({tag, "_busy_before_calc"}, 128'(busy_o), 128'd0);
        while (!valid_o && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(d));
        chk({tag, "_busy_in_send"}, 128'(busy_o), 128'd1);
        while (valid_o && n < 100) begin
            obs = {obs[126:0], dout_o};
            n++;
            @(negedge clock);
        end
        chk({tag, "_valid_len"}, 128'(n), 128'(lout));
        chk({tag, "_frame"}, obs, exp);
        chk({tag, "_idle"}, 128'({dout_o, valid_o, busy_o}), 128'd0);
    endtask

    initial begin
        set_din(1'b0);
        #3;
        chk("reset_outputs", 128'({dout_o, valid_o, busy_o}), 128'd0);
        @(negedge clock);
        reset = 1'b1;

        drive_frame(8'h0, 0, 2'b00, 64'h1234, 64'h5678);
        capture(28, 128'h960_6912, "add_1234_5678");
        drive_frame(8'h0, 0, 2'b00, 64'h9999, 64'h0001);
        capture(28, 128'h961_0000, "add_9999_0001");
        // Next frame starts on the very first cycle after dout_valid drops.
        drive_frame(8'h0, 0, 2'b01, 64'h0100, 64'h0001);
        capture(28, 128'h960_0099, "sub_0100_0001");
        drive_frame(8'h0, 0, 2'b01, 64'h0001, 64'h0002);
        capture(28, 128'h961_9999, "sub_0001_0002");
        drive_frame(8'h0, 0, 2'b10, 64'h4321, 64'h4321);
        capture(28, 128'h960_0000, "cmp_equal");
        drive_frame(8'h0, 0, 2'b10, 64'h5000, 64'h4999);
        capture(28, 128'h960_0001, "cmp_greater");
        drive_frame(8'h0, 0, 2'b10, 64'h0000, 64'h0001);
        capture(28, 128'h960_0002, "cmp_less");
        drive_frame(8'h0, 0, 2'b00, 64'h12A4, 64'h0001);
        capture(28, 128'h690_0000, "err_bad_digit");
        drive_frame(8'h0, 0, 2'b11, 64'h1234, 64'h5678);
        capture(28, 128'h690_0000, "err_op11");
        drive_frame(8'h5, 4, 2'b00, 64'h2222, 64'h3333);
        capture(28, 128'h960_5555, "hunt_after_junk");

        // A frame arriving while SEND is active must be dropped.
        drive_frame(8'h0, 0, 2'b00, 64'h0001, 64'h0001);
        fork
            capture(28, 128'h960_0002, "send_overlap_first");
            begin
                repeat (4) @(negedge clock);
                drive_frame(8'h0, 0, 2'b00, 64'h0000, 64'h0000);
            end
        join
        seen = 0;
        repeat (60) begin
            @(negedge clock);
            if (valid_o) seen = 1;
        end
        chk("send_overlap_dropped", 128'(seen), 128'd0);

        // Reset in the middle of RECV.
        for (int i = 7; i >= 0; i--) begin
            set_din(hdr[i]);
            @(negedge clock);
        end
        repeat (10) begin
            set_din(1'b1);
            @(negedge clock);
        end
        set_din(1'b0);
        #2 reset = 1'b0;
        #1 chk("reset_mid_recv", 128'({dout_o, valid_o, busy_o}), 128'd0);
        @(negedge clock);
        reset = 1'b1;

        // Reset while the header MSB is on dout.
        drive_frame(8'h0, 0, 2'b00, 64'h1234, 64'h5678);
        repeat (4) @(negedge clock);
        chk("pre_reset_send", 128'({dout_o, valid_o, busy_o}), 128'b111);
        #2 reset = 1'b0;
        #1 chk("reset_mid_send", 128'({dout_o, valid_o, busy_o}), 128'd0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (valid_o) seen = 1;
        end
        chk("no_resume_after_reset", 128'(seen), 128'd0);
        drive_frame(8'h0, 0, 2'b00, 64'h1234, 64'h5678);
        capture(28, 128'h960_6912, "add_after_reset");

        sel = 1;
        drive_frame(8'h0, 0, 2'b00, 64'h1, 64'h9);
        capture(16, 128'h96_1_0, "d1_add_1_9");

        sel = 2;
        drive_frame(8'h0, 0, 2'b00, 64'h9999_9999, 64'h0000_0001);
        capture(44, 128'h96_1_0000_0000, "d8_add_max");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
